// File: rtl/execute_div_sequencer.sv
// Sequences divw/divwu ops from execute into the iterative divider and returns result, XER OV/SO and CR0.
// Optional build macro DIV_SEQ_FASTPATH_EN: resolves b==1 and a==0 divides without the divider.
module execute_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_unsigned,
    input  logic             req_oe,
    input  logic             req_xer_so,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             div_enable,
    output logic             div_unsigned,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_out,
    input  logic             div_ov,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_value,
    output logic             res_ov,
    output logic             res_so,
    output logic             res_wr_xer,
    output logic [3:0]       res_cr0
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             uns_q, uns_d;
    logic             oe_q, oe_d;
    logic             so_q, so_d;
    logic             ov_q, ov_d;
    logic             en_q, en_d;
    logic             accept;

    // {LT,GT,EQ,SO} from a signed compare against zero
    function automatic logic [3:0] cr0_of(input logic [WIDTH-1:0] v, input logic so);
        logic neg;
        logic zero;
        neg  = v[WIDTH-1];
        zero = (v == '0);
        return {neg, ~neg & ~zero, zero, so};
    endfunction

    // Never accept while the divider still reports done from an earlier op.
    assign req_ready = (state_q == IDLE) & ~div_done & ~flush;
    assign accept    = req_valid & req_ready;

`ifdef DIV_SEQ_FASTPATH_EN
    logic fast_one;
    logic fast_zero;

    assign fast_one  = (req_b == WIDTH'(1));
    assign fast_zero = (req_a == '0) && (req_b != '0);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        val_d   = val_q;
        uns_d   = uns_q;
        oe_d    = oe_q;
        so_d    = so_q;
        ov_d    = ov_q;
        en_d    = en_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = req_a;
                    b_d   = req_b;
                    uns_d = req_unsigned;
                    oe_d  = req_oe;
                    so_d  = req_xer_so;
`ifdef DIV_SEQ_FASTPATH_EN
                    if (fast_one || fast_zero) begin
                        val_d   = fast_one ? req_a : '0;
                        ov_d    = 1'b0;
                        state_d = RESULT;
                    end else begin
                        en_d    = 1'b1;
                        state_d = RUN;
                    end
`else
                    en_d    = 1'b1;
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                // Flush wins even when done arrives in the same cycle.
                if (flush) begin
                    en_d    = 1'b0;
                    state_d = DRAIN;
                end else if (div_done) begin
                    val_d   = div_out;
                    ov_d    = div_ov;
                    en_d    = 1'b0;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (res_ready) begin
                    state_d = div_done ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                en_d = 1'b0;
                if (!div_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            val_q   <= '0;
            uns_q   <= 1'b0;
            oe_q    <= 1'b0;
            so_q    <= 1'b0;
            ov_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            val_q   <= val_d;
            uns_q   <= uns_d;
            oe_q    <= oe_d;
            so_q    <= so_d;
            ov_q    <= ov_d;
            en_q    <= en_d;
        end
    end

    assign div_enable   = en_q;
    assign div_unsigned = uns_q;
    assign div_a        = a_q;
    assign div_b        = b_q;

    assign res_valid  = (state_q == RESULT);
    assign res_value  = val_q;
    assign res_ov     = ov_q & oe_q;
    assign res_so     = so_q | res_ov;
    assign res_wr_xer = oe_q;
    // CR0 is forced to zero outside RESULT so the port reads 0 out of reset.
    assign res_cr0    = res_valid ? cr0_of(val_q, res_so) : 4'b0000;

endmodule
